// File: rtl/dog_diff_pipe.sv
// dog_diff_pipe
//   Two-stage Difference-of-Gaussian pipeline. Each accepted beat carries
//   N_SCALES co-located blurred pixels. The block emits N_SCALES-1 signed
//   differences (scale k+1 minus scale k), one threshold flag per pair and the
//   raster position of the beat.
//
//   Stage 1 forms the exact PIX_W+1 bit differences. Stage 2 applies the output
//   mode and computes the flags.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle
//   in_pix     scale k at [k*PIX_W +: PIX_W], unsigned
//   mode       0 raw, 1 saturate, 2 absolute, 3 saturate; latched at frame start
//   out_valid  output beat valid
//   out_ready  downstream accepts output beat
//   out_diff   pair k at [k*OUT_W +: OUT_W], two's complement
//   out_flag   bit k = |exact diff k| > THRESH
//   out_x      column of the output beat
//   out_y      row of the output beat
//   out_last   final pixel of the frame
//
// Handshake (both sides)
//   A beat transfers on a rising edge where valid && ready. A producer keeps
//   valid and data stable until the transfer happens. out_* are held stable
//   while out_valid && !out_ready.
//
//   in_ready depends only on pipeline state and out_ready, never on in_valid:
//     in_ready = !rst && (!s1_valid || !s2_valid || out_ready)
module dog_diff_pipe #(
   parameter int PIX_W    = 8,
   parameter int N_SCALES = 4,
   parameter int OUT_W    = 9,
   parameter int COLS     = 640,
   parameter int ROWS     = 480,
   parameter int THRESH   = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_SCALES*PIX_W-1:0]     in_pix,
   input  logic [1:0]                    mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [(N_SCALES-1)*OUT_W-1:0] out_diff,
   output logic [N_SCALES-2:0]           out_flag,
   output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_x,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_y,
   output logic                          out_last
);

   localparam int NP = N_SCALES - 1;
   localparam int DW = PIX_W + 1;
   // Working width: wide enough for the exact difference, its magnitude and
   // the output clamp limits, with one spare bit so negation never overflows.
   localparam int CW = ((DW > OUT_W) ? DW : OUT_W) + 1;
   localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] MODE_ABS = 2'd2;

   localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CW-1:0] MIN_V = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [CW-1:0]        THR_V = CW'(THRESH);

   // ---------------- position counters and mode latch ----------------
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    mode_q;
   logic [1:0]    mode_eff;
   logic          frame_start;
   logic          pos_last;

   // ---------------- stage registers ----------------
   logic               s1_valid_q;
   logic [NP*DW-1:0]   s1_d_q, s1_d_d;
   logic [XW-1:0]      s1_x_q;
   logic [YW-1:0]      s1_y_q;
   logic               s1_last_q;
   logic [1:0]         s1_mode_q;

   logic               s2_valid_q;
   logic [NP*OUT_W-1:0] s2_diff_q, s2_diff_d;
   logic [NP-1:0]      s2_flag_q, s2_flag_d;
   logic [XW-1:0]      s2_x_q;
   logic [YW-1:0]      s2_y_q;
   logic               s2_last_q;

   logic s2_load;
   logic s1_load;
   logic accept;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   assign frame_start = (x_q == '0) && (y_q == '0);
   assign pos_last    = (x_q == XW'(COLS-1)) && (y_q == YW'(ROWS-1));

   // The frame's first beat uses the live mode input; every other beat uses the
   // latched copy. The mode rides with the beat, so trailing beats of the old
   // frame that are still in flight keep their own mode.
   assign mode_eff = frame_start ? mode : mode_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (x_q == XW'(COLS-1)) begin
         x_d = '0;
         y_d = (y_q == YW'(ROWS-1)) ? '0 : y_q + 1'b1;
      end else begin
         x_d = x_q + 1'b1;
      end
   end

   // Stage 1: exact difference. A DW-bit wrap-around subtraction is exact,
   // because the result lies in [-(2^PIX_W-1), 2^PIX_W-1].
   always_comb begin
      s1_d_d = '0;
      for (int k = 0; k < NP; k++) begin
         s1_d_d[k*DW +: DW] = {1'b0, in_pix[(k+1)*PIX_W +: PIX_W]}
                            - {1'b0, in_pix[k*PIX_W +: PIX_W]};
      end
   end

   // Stage 2: mode and flag.
   // Raw and saturate share one path. When OUT_W >= DW the clamp never
   // engages, so raw equals sign extension. When OUT_W < DW, raw is defined to
   // behave as saturate.
   for (genvar k = 0; k < NP; k++) begin : g_pair
      logic signed [CW-1:0] d_ext;
      logic signed [CW-1:0] d_mag;
      logic signed [CW-1:0] d_sat;
      logic signed [CW-1:0] d_absc;

      assign d_ext  = {{(CW-DW){s1_d_q[k*DW + DW - 1]}}, s1_d_q[k*DW +: DW]};
      assign d_mag  = d_ext[CW-1] ? -d_ext : d_ext;
      assign d_sat  = (d_ext > MAX_V) ? MAX_V : ((d_ext < MIN_V) ? MIN_V : d_ext);
      assign d_absc = (d_mag > MAX_V) ? MAX_V : d_mag;

      assign s2_diff_d[k*OUT_W +: OUT_W] = (s1_mode_q == MODE_ABS) ? d_absc[OUT_W-1:0]
                                                                   : d_sat[OUT_W-1:0];
      // The flag uses the pre-clamp magnitude, so it does not depend on the mode.
      assign s2_flag_d[k] = $unsigned(d_mag) > THR_V;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         y_q        <= '0;
         mode_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_d_q     <= '0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_last_q  <= 1'b0;
         s1_mode_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_diff_q  <= '0;
         s2_flag_q  <= '0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            x_q <= x_d;
            y_q <= y_d;
            if (frame_start) begin
               mode_q <= mode;
            end
         end
         // accept implies s1_load, so an accepted beat always has a slot.
         if (s1_load) begin
            s1_valid_q <= accept;
            if (accept) begin
               s1_d_q    <= s1_d_d;
               s1_x_q    <= x_q;
               s1_y_q    <= y_q;
               s1_last_q <= pos_last;
               s1_mode_q <= mode_eff;
            end
         end
         if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_diff_q <= s2_diff_d;
               s2_flag_q <= s2_flag_d;
               s2_x_q    <= s1_x_q;
               s2_y_q    <= s1_y_q;
               s2_last_q <= s1_last_q;
            end
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign out_diff  = s2_diff_q;
   assign out_flag  = s2_flag_q;
   assign out_x     = s2_x_q;
   assign out_y     = s2_y_q;
   assign out_last  = s2_last_q;

endmodule

// File: tb/tb_dog_diff_pipe.sv
// Testbench for dog_diff_pipe with PIX_W=8, N_SCALES=3, COLS=4, ROWS=2, THRESH=3.
// u_dut uses OUT_W=9. u_sat uses OUT_W=6 and sees the same stimulus, which
// exercises clamping.
module tb_dog_diff_pipe;

   localparam int PIX_W    = 8;
   localparam int N_SCALES = 3;
   localparam int OUT_W    = 9;
   localparam int COLS     = 4;
   localparam int ROWS     = 2;
   localparam int THRESH   = 3;
   localparam int NP       = N_SCALES - 1;
   localparam int BW       = 1 + 1 + 2 + NP + NP*OUT_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst;
   logic                      in_valid;
   logic                      out_ready;
   logic [1:0]                mode;
   logic [N_SCALES*PIX_W-1:0] in_pix;

   logic                      in_ready;
   logic                      out_valid;
   logic [NP*OUT_W-1:0]       out_diff;
   logic [NP-1:0]             out_flag;
   logic [1:0]                out_x;
   logic [0:0]                out_y;
   logic                      out_last;

   logic                      sat_in_ready;
   logic                      sat_valid;
   logic [NP*6-1:0]           sat_diff;
   logic [NP-1:0]             sat_flag;
   logic [1:0]                sat_x;
   logic [0:0]                sat_y;
   logic                      sat_last;

   dog_diff_pipe #(.PIX_W(PIX_W), .N_SCALES(N_SCALES), .OUT_W(OUT_W),
                   .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pix(in_pix), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_diff(out_diff), .out_flag(out_flag), .out_x(out_x), .out_y(out_y),
      .out_last(out_last)
   );

   dog_diff_pipe #(.PIX_W(PIX_W), .N_SCALES(N_SCALES), .OUT_W(6),
                   .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
      .in_pix(in_pix), .mode(mode), .out_valid(sat_valid), .out_ready(out_ready),
      .out_diff(sat_diff), .out_flag(sat_flag), .out_x(sat_x), .out_y(sat_y),
      .out_last(sat_last)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [BW-1:0] exp_q[$];
   logic [N_SCALES*PIX_W-1:0] pix_tab[$];
   logic [1:0] mode_tab[$];
   int tb_x;
   int tb_y;
   logic [1:0] tb_mode;

   function automatic logic [N_SCALES*PIX_W-1:0] pix3(input int s0, input int s1, input int s2);
      return {s2[7:0], s1[7:0], s0[7:0]};
   endfunction

   // Reference model for one beat, written in integer arithmetic.
   function automatic logic [BW-1:0] exp_beat(input logic [N_SCALES*PIX_W-1:0] p,
                                              input int x, input int y, input logic [1:0] m);
      logic [NP*OUT_W-1:0] dv;
      logic [NP-1:0] fl;
      int a, b, d, ad, v;
      logic [1:0] xv;
      logic yv, lv;
      dv = '0;
      fl = '0;
      for (int k = 0; k < NP; k++) begin
         a  = int'(p[k*PIX_W +: PIX_W]);
         b  = int'(p[(k+1)*PIX_W +: PIX_W]);
         d  = b - a;
         ad = (d < 0) ? -d : d;
         if (m == 2'd2) v = (ad > 255) ? 255 : ad;
         else           v = (d > 255) ? 255 : ((d < -256) ? -256 : d);
         dv[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
         fl[k] = (ad > THRESH);
      end
      xv = x[1:0];
      yv = y[0];
      lv = (x == COLS-1) && (y == ROWS-1);
      return {lv, yv, xv, fl, dv};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; in_pix = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      tb_x = 0; tb_y = 0; tb_mode = 2'd0;
      exp_q.delete();
   endtask

   // Streams pix_tab/mode_tab (at most n beats). The stall window holds
   // out_ready low. Every popped output is checked against exp_q, and held
   // outputs must stay stable.
   task automatic run_stream(input int n, input int stall_from, input int stall_len,
                             input bit drain, output int acc_in_stall);
      int idx = 0;
      int cyc = 0;
      bit hold_chk = 1'b0;
      bit stalled;
      logic [BW-1:0] held = '0;
      logic [BW-1:0] obs;
      logic [BW-1:0] e;
      logic [1:0] m_eff;
      acc_in_stall = 0;
      while (cyc < 300) begin
         if (drain ? (idx >= n && exp_q.size() == 0) : (idx >= n)) break;
         stalled   = (cyc >= stall_from) && (cyc < stall_from + stall_len);
         out_ready = !stalled;
         in_valid  = (idx < n);
         if (idx < n) begin
            in_pix = pix_tab[idx];
            mode   = mode_tab[idx];
         end
         #1;
         obs = {out_last, out_y, out_x, out_flag, out_diff};
         if (hold_chk) begin
            checks++;
            if (obs !== held) $display("FAIL hold_stable cyc=%0d got %h want %h", cyc, obs, held);
            if (obs !== held) errors++;
         end
         hold_chk = out_valid && !out_ready;
         held = obs;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_output cyc=%0d got %h want none", cyc, obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL beat cyc=%0d got %h want %h", cyc, obs, e);
               end
            end
         end
         if (stall_len > 0 && stalled && cyc >= stall_from + 2) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready cyc=%0d got %b want 0", cyc, in_ready);
            end
         end
         if (in_valid && in_ready) begin
            m_eff = (tb_x == 0 && tb_y == 0) ? mode : tb_mode;
            if (tb_x == 0 && tb_y == 0) tb_mode = mode;
            exp_q.push_back(exp_beat(in_pix, tb_x, tb_y, m_eff));
            if (tb_x == COLS-1) begin
               tb_x = 0;
               tb_y = (tb_y == ROWS-1) ? 0 : tb_y + 1;
            end else begin
               tb_x++;
            end
            if (stalled) acc_in_stall++;
            idx++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 300) begin
         errors++;
         $display("FAIL stream_timeout got %0d cycles want < 300", cyc);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (drain) begin
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained_idle got out_valid=%b want 0", out_valid);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; in_pix = '0;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_diff, out_flag, out_x, out_y, out_last} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {out_valid, out_diff, out_flag, out_x, out_y, out_last});
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_in_ready got %b want 1", in_ready);
      end
      tb_x = 0; tb_y = 0; tb_mode = 2'd0;
   endtask

   task automatic test_raw();
      do_reset();
      mode = 2'd0; in_valid = 1'b1; in_pix = pix3(5, 6, 20);
      @(posedge clk); #1;
      in_pix = pix3(6, 5, 5);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL raw_latency1 got out_valid=%b want 0", out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_diff, out_flag, out_x} !== {1'b1, 9'd14, 9'd1, 2'b10, 2'd0}) begin
         errors++;
         $display("FAIL raw_beat0 got v=%b d=%h f=%b x=%0d want v=1 d=%h f=10 x=0",
                  out_valid, out_diff, out_flag, out_x, {9'd14, 9'd1});
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_diff, out_flag, out_x} !== {1'b1, 9'd0, 9'h1FF, 2'b00, 2'd1}) begin
         errors++;
         $display("FAIL raw_beat1 got v=%b d=%h f=%b x=%0d want v=1 d=%h f=00 x=1",
                  out_valid, out_diff, out_flag, out_x, {9'd0, 9'h1FF});
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL raw_idle got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_extremes();
      logic [1:0] modes [2];
      logic [11:0] sat_want [2];
      logic [17:0] main_want [2];
      modes[0] = 2'd1; sat_want[0] = {6'h1F, 6'h20}; main_want[0] = {9'h0FF, 9'h101};
      modes[1] = 2'd2; sat_want[1] = {6'h1F, 6'h1F}; main_want[1] = {9'h0FF, 9'h0FF};
      for (int i = 0; i < 2; i++) begin
         do_reset();
         mode = modes[i]; in_valid = 1'b1; in_pix = pix3(255, 0, 255);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if ({sat_valid, sat_diff, sat_flag} !== {1'b1, sat_want[i], 2'b11}) begin
            errors++;
            $display("FAIL extreme_sat%0d got v=%b d=%h f=%b want v=1 d=%h f=11",
                     i, sat_valid, sat_diff, sat_flag, sat_want[i]);
         end
         checks++;
         if ({out_diff, out_flag} !== {main_want[i], 2'b11}) begin
            errors++;
            $display("FAIL extreme_wide%0d got d=%h f=%b want d=%h f=11",
                     i, out_diff, out_flag, main_want[i]);
         end
         checks++;
         if ({sat_x, sat_y, sat_last, sat_in_ready} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL extreme_pos%0d got x=%0d y=%0d l=%b r=%b want 0 0 0 1",
                     i, sat_x, sat_y, sat_last, sat_in_ready);
         end
      end
   endtask

   task automatic test_raster();
      int acc;
      do_reset();
      pix_tab.delete(); mode_tab.delete();
      for (int i = 0; i < 9; i++) begin
         pix_tab.push_back(pix3(i*7, i*3 + 1, 200 - i*20));
         mode_tab.push_back(2'd0);
      end
      run_stream(9, 0, 0, 1'b1, acc);
   endtask

   task automatic test_back_to_back_backpressure();
      int acc;
      do_reset();
      pix_tab.delete(); mode_tab.delete();
      for (int i = 0; i < 8; i++) begin
         pix_tab.push_back(pix3(100 + i, 90 + i*5, 50));
         mode_tab.push_back(2'd0);
      end
      run_stream(8, 0, 5, 1'b1, acc);
      checks++;
      if (acc !== 2) begin
         errors++;
         $display("FAIL stall_accepts got %0d want 2", acc);
      end
   endtask

   task automatic test_mode_latch();
      int acc;
      do_reset();
      pix_tab.delete(); mode_tab.delete();
      for (int i = 0; i < 12; i++) begin
         pix_tab.push_back(pix3(10, 3, 1));
         mode_tab.push_back((i < 2) ? 2'd0 : 2'd2);
      end
      run_stream(12, 0, 0, 1'b1, acc);
   endtask

   task automatic test_reset_mid_frame();
      int acc;
      do_reset();
      pix_tab.delete(); mode_tab.delete();
      for (int i = 0; i < 8; i++) begin
         pix_tab.push_back(pix3(20, 40 + i, 10));
         mode_tab.push_back(2'd0);
      end
      run_stream(5, 0, 0, 1'b0, acc);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_full got out_valid=%b want 1", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_flush got v=%b r=%b want 0 0", out_valid, in_ready);
      end
      rst = 1'b0;
      tb_x = 0; tb_y = 0; tb_mode = 2'd0;
      exp_q.delete();
      pix_tab.delete(); mode_tab.delete();
      for (int i = 0; i < 4; i++) begin
         pix_tab.push_back(pix3(60, 50 - i*10, 70));
         mode_tab.push_back(2'd1);
      end
      run_stream(4, 0, 0, 1'b1, acc);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; in_pix = '0;
      tb_x = 0; tb_y = 0; tb_mode = 2'd0;
      test_reset();
      test_raw();
      test_extremes();
      test_raster();
      test_back_to_back_backpressure();
      test_mode_latch();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
